// File: rtl/seq_det_scheduler_pkg.sv
// Shared types and next-state function for the time-shared equal-bit run detector.
// Context is {lastbit, cnt}; cnt is held at CNT_MAXW bits here and narrowed per instance.
package seq_det_pkg;

    localparam int unsigned RUN_LEN_DEF = 4;
    localparam int unsigned CNT_MAXW    = 4;  // enough for RUN_LEN up to 15

    function automatic int unsigned cnt_w(input int unsigned run_len);
        return $clog2(run_len + 1);
    endfunction

    function automatic int unsigned ctx_w(input int unsigned run_len);
        return 1 + cnt_w(run_len);
    endfunction

    typedef struct packed {
        logic                lastbit;
        logic [CNT_MAXW-1:0] cnt;
    } ctx_t;

    localparam ctx_t IDLE = '{lastbit: 1'b0, cnt: '0};

    function automatic ctx_t next_ctx(input ctx_t c, input logic b, input logic clr,
                                      input int unsigned run_len);
        ctx_t n;
        n = IDLE;
        if (clr) begin
            n = IDLE;
        end else if (c.cnt == '0 || b != c.lastbit) begin
            n.lastbit = b;
            n.cnt     = CNT_MAXW'(1);
        end else begin
            n.lastbit = b;
            n.cnt     = (c.cnt >= CNT_MAXW'(run_len)) ? CNT_MAXW'(run_len)
                                                      : c.cnt + CNT_MAXW'(1);
        end
        return n;
    endfunction

endpackage

// File: rtl/seq_det_scheduler_if.sv
// Channel bus of seq_det_scheduler: requests, bits, clears, grants, flags and debug taps.
// cnt_dbg exists only when SEQ_DET_SCHED_CNT_EN is defined.
interface seq_det_scheduler_if
    import seq_det_pkg::*;
#(
    parameter int unsigned NCH     = 4,
    parameter int unsigned RUN_LEN = RUN_LEN_DEF
);
    localparam int unsigned IW   = $clog2(NCH);
    localparam int unsigned CTXW = ctx_w(RUN_LEN);

    logic [NCH-1:0]  req;
    logic [NCH-1:0]  bit_in;
    logic [NCH-1:0]  clr;
    logic [NCH-1:0]  gnt;
    logic [NCH-1:0]  z;
    logic            det_pulse;
    logic [IW-1:0]   det_ch;
    logic [CTXW-1:0] ctx_dbg;
    logic [IW-1:0]   dbg_sel;
`ifdef SEQ_DET_SCHED_CNT_EN
    logic [7:0]      cnt_dbg;

    modport master (
        output req, bit_in, clr, dbg_sel,
        input  gnt, z, det_pulse, det_ch, ctx_dbg, cnt_dbg
    );
    modport slave (
        input  req, bit_in, clr, dbg_sel,
        output gnt, z, det_pulse, det_ch, ctx_dbg, cnt_dbg
    );
`else
    modport master (
        output req, bit_in, clr, dbg_sel,
        input  gnt, z, det_pulse, det_ch, ctx_dbg
    );
    modport slave (
        input  req, bit_in, clr, dbg_sel,
        output gnt, z, det_pulse, det_ch, ctx_dbg
    );
`endif

endinterface

// File: rtl/seq_det_scheduler_rr_arb.sv
// Round-robin arbiter: one-hot grant searched from the pointer, pointer moves past the winner.
// Grant is combinational and forced low while reset is asserted.
module seq_rr_arb #(
    parameter int unsigned NCH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NCH-1:0]         req_i,
    output logic [NCH-1:0]         gnt_o,
    output logic [$clog2(NCH)-1:0] gnt_idx_o
);
    localparam int unsigned IW = $clog2(NCH);

    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;
    int unsigned   j;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        j         = 0;
        for (int unsigned i = 0; i < NCH; i++) begin
            j = (32'(ptr_q) + i) % NCH;
            if (!found && req_i[j]) begin
                found     = 1'b1;
                gnt_o[j]  = 1'b1;
                gnt_idx_o = IW'(j);
            end
        end
        if (!rst_ni) begin
            gnt_o = '0;
            found = 1'b0;
        end
        ptr_d = ptr_q;
        if (found) begin
            ptr_d = (32'(gnt_idx_o) == NCH - 1) ? '0 : gnt_idx_o + IW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/seq_det_scheduler.sv
// Time-shared run-of-RUN_LEN detector serving NCH serial channels through a round-robin grant.
// Optional macro SEQ_DET_SCHED_CNT_EN adds per-channel 8-bit saturating detect counters (cnt_dbg).
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter int unsigned NCH     = 4,
    parameter int unsigned RUN_LEN = RUN_LEN_DEF
) (
    input  logic               Clock,
    input  logic               Resetn,
    seq_det_scheduler_if.slave bus
);
    localparam int unsigned IW   = $clog2(NCH);
    localparam int unsigned CNTW = cnt_w(RUN_LEN);
    localparam int unsigned CTXW = ctx_w(RUN_LEN);

    logic [NCH-1:0]  gnt;
    logic [IW-1:0]   gnt_idx;
    logic            found;
    logic            sel_ok;

    logic [CTXW-1:0] ctx_q [NCH];
    logic [CTXW-1:0] ctx_d [NCH];
    logic [NCH-1:0]  z_q, z_d;
    logic            det_pulse_q, det_pulse_d;
    logic [IW-1:0]   det_ch_q, det_ch_d;

    ctx_t            cur, nxt;
    logic            hit;

    seq_rr_arb #(.NCH(NCH)) u_arb (
        .clk_i     (Clock),
        .rst_ni    (Resetn),
        .req_i     (bus.req),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign found = |gnt;

    // Only the granted channel's context passes through the shared next-state logic.
    always_comb begin
        ctx_d       = ctx_q;
        z_d         = z_q;
        det_pulse_d = 1'b0;
        det_ch_d    = det_ch_q;
        cur         = IDLE;
        nxt         = IDLE;
        hit         = 1'b0;
        if (found) begin
            cur.lastbit      = ctx_q[gnt_idx][CTXW-1];
            cur.cnt          = CNT_MAXW'(ctx_q[gnt_idx][CNTW-1:0]);
            nxt              = next_ctx(cur, bus.bit_in[gnt_idx], bus.clr[gnt_idx], RUN_LEN);
            ctx_d[gnt_idx]   = {nxt.lastbit, nxt.cnt[CNTW-1:0]};
            hit              = (nxt.cnt == CNT_MAXW'(RUN_LEN));
            z_d[gnt_idx]     = hit;
            det_pulse_d      = hit;
            if (hit) begin
                det_ch_d = gnt_idx;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ctx_q       <= '{default: '0};
            z_q         <= '0;
            det_pulse_q <= 1'b0;
            det_ch_q    <= '0;
        end else begin
            ctx_q       <= ctx_d;
            z_q         <= z_d;
            det_pulse_q <= det_pulse_d;
            det_ch_q    <= det_ch_d;
        end
    end

    assign sel_ok        = (32'(bus.dbg_sel) < NCH);
    assign bus.gnt       = gnt;
    assign bus.z         = z_q;
    assign bus.det_pulse = det_pulse_q;
    assign bus.det_ch    = det_ch_q;
    assign bus.ctx_dbg   = sel_ok ? ctx_q[bus.dbg_sel] : '0;

`ifdef SEQ_DET_SCHED_CNT_EN
    logic [7:0] dcnt_q [NCH];
    logic [7:0] dcnt_d [NCH];

    always_comb begin
        dcnt_d = dcnt_q;
        if (found) begin
            if (bus.clr[gnt_idx]) begin
                dcnt_d[gnt_idx] = '0;
            end else if (hit && dcnt_q[gnt_idx] != '1) begin
                dcnt_d[gnt_idx] = dcnt_q[gnt_idx] + 8'd1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            dcnt_q <= '{default: '0};
        end else begin
            dcnt_q <= dcnt_d;
        end
    end

    assign bus.cnt_dbg = sel_ok ? dcnt_q[bus.dbg_sel] : '0;
`endif

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Self-checking bench for seq_det_scheduler: table-driven single-channel vectors with a
// scoreboard queue, plus hand sequences for reset, ungranted clear and round-robin service.
module tb_seq_det_scheduler;

    localparam int NCH = 4;
    localparam int RL  = 4;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;

    always #5 Clock = ~Clock;

    seq_det_scheduler_if #(.NCH(NCH), .RUN_LEN(RL)) bus ();

    seq_det_scheduler #(.NCH(NCH), .RUN_LEN(RL)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    typedef struct {
        int       ch;
        bit       b;
        bit       c;
        bit       ez;
        bit       ep;
        logic [3:0] ectx;
        int       edch;
    } vec_t;

    typedef struct {
        int       ch;
        bit       ez;
        bit       ep;
        logic [3:0] ectx;
        int       edch;
    } exp_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sbq[$];
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_empty: got no entry expected one at %0t", $time);
        end else begin
            e = sbq.pop_front();
            chk("z",         32'(bus.z[e.ch]),    32'(e.ez));
            chk("det_pulse", 32'(bus.det_pulse),  32'(e.ep));
            chk("det_ch",    32'(bus.det_ch),     32'(e.edch));
            chk("ctx_dbg",   32'(bus.ctx_dbg),    32'(e.ectx));
        end
    endtask

    task automatic step(input vec_t v);
        logic [3:0] oh;
        oh = 4'(1) << v.ch;
        @(negedge Clock);
        bus.req         = oh;
        bus.bit_in[v.ch] = v.b;
        bus.clr         = v.c ? oh : 4'b0000;
        bus.dbg_sel     = 2'(v.ch);
        #1;
        chk("gnt", 32'(bus.gnt), 32'(oh));
        sbq.push_back('{v.ch, v.ez, v.ep, v.ectx, v.edch});
        @(posedge Clock);
        #1;
        bus.req = '0;
        bus.clr = '0;
        pop_check();
    endtask

    task automatic pulse_reset();
        @(negedge Clock);
        bus.req = '0;
        Resetn  = 1'b0;
        @(negedge Clock);
        Resetn  = 1'b1;
    endtask

    int         mlast [NCH];
    int         mcnt  [NCH];
    int         mptr;
    int         mdch;
    int         e_ch;
    int         b;
    bit         h;
    logic [3:0] bits;
    int         npulse;

    initial begin
        bus.req     = '1;
        bus.bit_in  = '0;
        bus.clr     = '0;
        bus.dbg_sel = '0;
        #12;
        chk("rst_gnt",       32'(bus.gnt),       0);
        chk("rst_z",         32'(bus.z),         0);
        chk("rst_det_pulse", 32'(bus.det_pulse), 0);
        chk("rst_det_ch",    32'(bus.det_ch),    0);
        chk("rst_ctx",       32'(bus.ctx_dbg),   0);
        bus.req = '0;
        @(negedge Clock);
        Resetn = 1'b1;

        // ch, bit, clr, z, pulse, ctx {lastbit,cnt}, det_ch
        tbl.push_back('{0, 0, 0, 0, 0, 4'b0001, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 4'b0010, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 4'b0011, 0});
        tbl.push_back('{0, 0, 0, 1, 1, 4'b0100, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 4'b1001, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 4'b1010, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 4'b1011, 0});
        tbl.push_back('{1, 0, 0, 0, 0, 4'b0001, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 4'b1001, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 4'b1010, 0});
        tbl.push_back('{1, 1, 0, 0, 0, 4'b1011, 0});
        tbl.push_back('{1, 1, 0, 1, 1, 4'b1100, 1});
        tbl.push_back('{0, 0, 0, 1, 1, 4'b0100, 0});
        tbl.push_back('{2, 1, 0, 0, 0, 4'b1001, 0});
        tbl.push_back('{2, 1, 0, 0, 0, 4'b1010, 0});
        tbl.push_back('{2, 1, 0, 0, 0, 4'b1011, 0});
        tbl.push_back('{2, 1, 0, 1, 1, 4'b1100, 2});
        tbl.push_back('{2, 1, 1, 0, 0, 4'b0000, 2});
        tbl.push_back('{3, 1, 0, 0, 0, 4'b1001, 2});
        foreach (tbl[i]) step(tbl[i]);

        // clr on a channel that is not granted must leave its context alone
        @(negedge Clock);
        bus.req     = 4'b0100;
        bus.bit_in  = 4'b0000;
        bus.clr     = 4'b1000;
        bus.dbg_sel = 2'd3;
        #1;
        chk("gnt_clr_ungranted", 32'(bus.gnt), 32'h4);
        @(posedge Clock);
        #1;
        bus.req = '0;
        bus.clr = '0;
        chk("ctx3_after_clr", 32'(bus.ctx_dbg), 32'h9);
        chk("z3_after_clr",   32'(bus.z[3]),    0);
        bus.dbg_sel = 2'd2;
        #1;
        chk("ctx2_new_run",   32'(bus.ctx_dbg), 32'h1);

        // channel 0 to {0,3}, then reset mid-stream with its req pending
        step('{0, 1, 0, 0, 0, 4'b1001, 2});
        step('{0, 0, 0, 0, 0, 4'b0001, 2});
        step('{0, 0, 0, 0, 0, 4'b0010, 2});
        step('{0, 0, 0, 0, 0, 4'b0011, 2});
        @(negedge Clock);
        bus.req     = 4'b0001;
        bus.bit_in  = 4'b0000;
        bus.dbg_sel = 2'd0;
        Resetn      = 1'b0;
        #1;
        chk("mid_rst_gnt",    32'(bus.gnt),       0);
        chk("mid_rst_z",      32'(bus.z),         0);
        chk("mid_rst_pulse",  32'(bus.det_pulse), 0);
        chk("mid_rst_det_ch", 32'(bus.det_ch),    0);
        chk("mid_rst_ctx",    32'(bus.ctx_dbg),   0);
        @(negedge Clock);
        Resetn = 1'b1;
        #1;
        chk("regrant_gnt", 32'(bus.gnt), 32'h1);
        sbq.push_back('{0, 1'b0, 1'b0, 4'b0001, 0});
        @(posedge Clock);
        #1;
        bus.req = '0;
        pop_check();

        // round-robin with every channel requesting, pointer starting at 0
        pulse_reset();
        bits = 4'b1010;
        for (int i = 0; i < NCH; i++) begin
            mlast[i] = 0;
            mcnt[i]  = 0;
        end
        mptr = 0;
        mdch = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge Clock);
            e_ch        = mptr;
            bus.req     = '1;
            bus.bit_in  = bits;
            bus.dbg_sel = 2'(e_ch);
            #1;
            chk("rr_gnt", 32'(bus.gnt), 32'(4'(1) << e_ch));
            b = int'(bits[e_ch]);
            if (mcnt[e_ch] > 0 && b == mlast[e_ch]) begin
                mcnt[e_ch] = (mcnt[e_ch] < RL) ? mcnt[e_ch] + 1 : RL;
            end else begin
                mcnt[e_ch] = 1;
            end
            mlast[e_ch] = b;
            h = (mcnt[e_ch] == RL);
            if (h) mdch = e_ch;
            sbq.push_back('{e_ch, h, h, 4'((mlast[e_ch] << 3) | mcnt[e_ch]), mdch});
            mptr = (e_ch + 1) % NCH;
            @(posedge Clock);
            #1;
            pop_check();
        end
        bus.req = '0;

`ifdef SEQ_DET_SCHED_CNT_EN
        pulse_reset();
        npulse = 0;
        @(negedge Clock);
        bus.req     = 4'b0001;
        bus.bit_in  = 4'b0000;
        bus.clr     = 4'b0000;
        bus.dbg_sel = 2'd0;
        for (int k = 0; k < 300; k++) begin
            @(posedge Clock);
            #1;
            if (bus.det_pulse) npulse++;
        end
        bus.req = '0;
        chk("pulse_count", 32'(npulse),      32'd297);
        chk("cnt_dbg_sat", 32'(bus.cnt_dbg), 32'd255);
        step('{0, 0, 1, 0, 0, 4'b0000, 0});
        chk("cnt_dbg_clr", 32'(bus.cnt_dbg), 32'd0);
`else
        npulse = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
